// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
//   Types and constants shared by the serial CLA subtractor.
//   SLICE_W : bits handled per cycle by the lookahead slice
//   state_t : controller states (IDLE, BUSY, DONE)
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_sub_serial_if.sv
// ---------------------------------------------------------------------------
// cla_sub_serial_if
//   Operand / result handshake bundle for cla_sub_serial.
//   Operand side : in_valid, in_ready, a, b, bin
//   Result side  : out_valid, out_ready, diff, bout, zero, ovf
//   master : producer/consumer view; slave : subtractor view
// ---------------------------------------------------------------------------
interface cla_sub_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );

endinterface

// File: rtl/cla_sub_slice.sv
// ---------------------------------------------------------------------------
// cla_sub_slice
//   Combinational 4-bit subtract slice with lookahead borrow.
//   a, b : slice operands      bin  : borrow into bit 0
//   d    : a - b - bin (4 bit) bout : borrow out of bit 3
//   Borrow generate g = ~a & b, propagate p = ~(a ^ b); every internal
//   borrow is a flat sum-of-products of g/p/bin rather than a ripple.
// ---------------------------------------------------------------------------
module cla_sub_slice
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               bin,
    output logic [SLICE_W-1:0] d,
    output logic               bout
);

    logic [SLICE_W-1:0] p, g;
    logic [SLICE_W:0]   br;

    assign p = ~(a ^ b);
    assign g = ~a & b;

    assign br[0] = bin;
    assign br[1] = g[0] | (p[0] & bin);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);
    assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d    = a ^ b ^ br[SLICE_W-1:0];
    assign bout = br[SLICE_W];

endmodule

// File: rtl/cla_sub_serial.sv
// ---------------------------------------------------------------------------
// cla_sub_serial
//   Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), one 4-bit
//   slice per cycle, LSB slice first; the borrow is carried between slices
//   in a register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cla_sub_serial_if.slave (operand and result handshakes)
//   Optional   : define SUB_OVF_FLAG_EN to produce the signed overflow flag;
//                otherwise ovf is tied low.
//   Timing     : operands accepted at edge N -> out_valid after edge
//                N+WIDTH/4+1. The extra DONE cycle evaluates the zero flag
//                from the registered diff, so the wide compare never sits
//                behind the slice borrow chain.
// ---------------------------------------------------------------------------
module cla_sub_serial
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    cla_sub_serial_if.slave  bus
);

    localparam int                SLICES = WIDTH / SLICE_W;
    localparam int                IDXW   = $clog2(SLICES);
    localparam logic [IDXW-1:0]   LAST   = IDXW'(SLICES - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q, diff_q;
    logic [IDXW-1:0]    idx_q;
    logic               br_q, bout_q, zero_q, out_valid_q;

    logic [SLICE_W-1:0] s_a, s_b, s_d;
    logic               s_bout;

    // single slice shared across all cycles, operands muxed by idx
    assign s_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign s_b = b_q[idx_q*SLICE_W +: SLICE_W];

    cla_sub_slice u_slice (
        .a    (s_a),
        .b    (s_b),
        .bin  (br_q),
        .d    (s_d),
        .bout (s_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)                 state_nxt = BUSY;
            BUSY:    if (idx_q == LAST)                state_nxt = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            idx_q       <= '0;
            br_q        <= 1'b0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q   <= bus.a;
                    b_q   <= bus.b;
                    br_q  <= bus.bin;
                    idx_q <= '0;
                end
                BUSY: begin
                    diff_q[idx_q*SLICE_W +: SLICE_W] <= s_d;
                    br_q  <= s_bout;
                    idx_q <= idx_q + IDXW'(1);
                    if (idx_q == LAST) bout_q <= s_bout;
                end
                DONE: begin
                    // first DONE cycle: full diff is registered, finish flags
                    if (!out_valid_q) begin
                        zero_q      <= (diff_q == '0);
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_OVF_FLAG_EN
    logic ovf_q;

    // overflow only possible when operand signs differ; captured with bout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (state == BUSY && idx_q == LAST)
            ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s_d[SLICE_W-1] != a_q[WIDTH-1]);
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_sub_serial.sv
// ---------------------------------------------------------------------------
// tb_cla_sub_serial
//   Scoreboard bench for cla_sub_serial (WIDTH=16). The driver pushes the
//   reference result of every accepted operation; a monitor pops and
//   compares whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_cla_sub_serial;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_sub_serial_if #(.WIDTH(W)) bus ();

    cla_sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } res_t;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rand_rdy = 1'b0;

    // reference: plain integer arithmetic on the operands
    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic bin);
        res_t r;
        int   sa, sbv, sd;
        r.diff = a - b - W'(bin);
        r.bout = ({1'b0, a} < ({1'b0, b} + 17'(bin)));
        r.zero = (r.diff == '0);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        sd  = sa - sbv - int'(bin);
`ifdef SUB_OVF_FLAG_EN
        r.ovf = (sd > 32767) || (sd < -32768);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: a result transfers at the next edge when valid && ready
    always @(negedge clk) begin
        res_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_result: got diff %0h want no result", bus.diff);
            end else begin
                e = sb.pop_front();
                chk("diff", 32'(bus.diff), 32'(e.diff));
                chk("bout", 32'(bus.bout), 32'(e.bout));
                chk("zero", 32'(bus.zero), 32'(e.zero));
                chk("ovf",  32'(bus.ovf),  32'(e.ovf));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // returns one tick after the accepting edge
    task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic bin);
        int k;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.bin = bin; bus.in_valid = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            chk("accept_timeout", 32'(k), 32'(0));
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            sb.push_back(model(a, b, bin));
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || !bus.in_ready) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("drain_timeout", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   k;
        res_t e1;

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_diff",      32'(bus.diff),      32'(0));
        chk("rst_bout",      32'(bus.bout),      32'(0));
        chk("rst_zero",      32'(bus.zero),      32'(0));
        chk("rst_ovf",       32'(bus.ovf),       32'(0));
        @(negedge clk) rst_n = 1'b1;

        // wrap 0x5 - 0x6, with fixed latency measurement
        send(16'h0005, 16'h0006, 1'b0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                k = i;
                break;
            end
        end
        chk("latency", 32'(k), 32'(5));

        send(16'h1234, 16'h1234, 1'b0);
        send(16'h0000, 16'h0000, 1'b1);
        send(16'h8000, 16'h0001, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        wait_drain();

        // consumer stall: result must hold, new operands must wait
        bus.out_ready = 1'b0;
        e1 = model(16'hA5A5, 16'h5A5A, 1'b1);
        send(16'hA5A5, 16'h5A5A, 1'b1);
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("stall_valid_seen", 32'(bus.out_valid), 32'(1));
        fork
            send(16'h0F0F, 16'h00FF, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_diff",      32'(bus.diff),      32'(e1.diff));
                    chk("stall_bout",      32'(bus.bout),      32'(e1.bout));
                    chk("stall_zero",      32'(bus.zero),      32'(e1.zero));
                    chk("stall_in_ready",  32'(bus.in_ready),  32'(0));
                    chk("stall_out_valid", 32'(bus.out_valid), 32'(1));
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        // reset after two BUSY cycles discards the operation
        send(16'h4321, 16'h0123, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("midrst_diff",      32'(bus.diff),      32'(0));
        chk("midrst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("midrst_bout",      32'(bus.bout),      32'(0));
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        send(16'h00FF, 16'h000F, 1'b0);
        wait_drain();

        // randomized operands with random consumer back-pressure
        rand_rdy = 1'b1;
        repeat (40) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
